// File: rtl/regfile_pkg.sv
// Shared constants, special-register kinds and slice helper for the multi-port register file.
package regfile_pkg;
  localparam int PC_IDX_DEF  = 31;
  localparam int SP_IDX_DEF  = 30;
  localparam int LR_IDX_DEF  = 29;
  localparam int ST_IDX_DEF  = 28;
  localparam int SP_STEP_DEF = 1;

  typedef enum logic [1:0] {SPC_NONE, SPC_PC, SPC_SP, SPC_ST} spc_e;

  // Low bit of port k's field in a flattened per-port bus of width w.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/regfile_mp_pc_if.sv
// Port bundle of the multi-port register file: read/write ports, side-band controls, special outputs.
interface regfile_mp_pc_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2,
  parameter int NWR = 2
);
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wa;
  logic [NWR*DW-1:0] wd;
  logic [DW-1:0]     st_in;
  logic              st_wr;
  logic              pc_inc;
  logic              sp_inc;
  logic              sp_dec;
  logic [DW-1:0]     pc_out;
  logic [DW-1:0]     sp_out;
  logic [DW-1:0]     lr_out;
  logic [DW-1:0]     st_out;

  modport master (
    output rd_en, ra, wr_en, wa, wd, st_in, st_wr, pc_inc, sp_inc, sp_dec,
    input  rd, pc_out, sp_out, lr_out, st_out
  );
  modport slave (
    input  rd_en, ra, wr_en, wa, wd, st_in, st_wr, pc_inc, sp_inc, sp_dec,
    output rd, pc_out, sp_out, lr_out, st_out
  );
endinterface

// File: rtl/regfile_wr_arb.sv
// Next-value resolver for one register: port priority (highest index wins), side-band
// PC/SP arithmetic, status override and zero-register masking.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int   DW      = 32,
  parameter int   AW      = 5,
  parameter int   NWR     = 2,
  parameter int   IDX     = 0,
  parameter spc_e KIND    = SPC_NONE,
  parameter bit   ZERO    = 1'b0,
  parameter int   SP_STEP = SP_STEP_DEF
) (
  input  logic [DW-1:0]     cur_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wa_i,
  input  logic [NWR*DW-1:0] wd_i,
  input  logic              pc_inc_i,
  input  logic              sp_inc_i,
  input  logic              sp_dec_i,
  input  logic              st_wr_i,
  input  logic [DW-1:0]     st_in_i,
  output logic [DW-1:0]     nxt_o
);
  logic hit;

  always_comb begin
    hit   = 1'b0;
    nxt_o = cur_i;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en_i[p] && wa_i[slice_lo(p, AW) +: AW] == AW'(IDX)) begin
        hit   = 1'b1;
        nxt_o = wd_i[slice_lo(p, DW) +: DW];
      end
    end
    // A port write is a branch / explicit SP load and beats the side-band step.
    if (KIND == SPC_PC && !hit && pc_inc_i) nxt_o = cur_i + DW'(1);
    if (KIND == SPC_SP && !hit && (sp_inc_i ^ sp_dec_i))
      nxt_o = sp_inc_i ? cur_i + DW'(SP_STEP) : cur_i - DW'(SP_STEP);
    if (KIND == SPC_ST && st_wr_i) nxt_o = st_in_i;
    if (ZERO) nxt_o = '0;
  end
endmodule

// File: rtl/regfile_mp_pc.sv
// Multi-port CPU register file with PC/SP/LR/ST special registers and registered read ports.
// REGFILE_BYPASS_EN: reads return the post-edge (resolved) value instead of the pre-edge value.
module regfile_mp_pc
  import regfile_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter bit ZERO_R0 = 1'b1,
  parameter int PC_IDX  = PC_IDX_DEF,
  parameter int SP_IDX  = SP_IDX_DEF,
  parameter int LR_IDX  = LR_IDX_DEF,
  parameter int ST_IDX  = ST_IDX_DEF,
  parameter int SP_STEP = SP_STEP_DEF
) (
  input logic           clk,
  input logic           rst,
  regfile_mp_pc_if.slave bus
);
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]     regs_q [DEPTH];
  logic [DW-1:0]     regs_d [DEPTH];
  logic [DW-1:0]     rd_d   [NRD];
  logic [NRD*DW-1:0] rd_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    localparam spc_e K = (i == PC_IDX) ? SPC_PC :
                         (i == SP_IDX) ? SPC_SP :
                         (i == ST_IDX) ? SPC_ST : SPC_NONE;
    regfile_wr_arb #(
      .DW(DW), .AW(AW), .NWR(NWR), .IDX(i), .KIND(K),
      .ZERO(ZERO_R0 && i == 0), .SP_STEP(SP_STEP)
    ) u_arb (
      .cur_i   (regs_q[i]),
      .wr_en_i (bus.wr_en),
      .wa_i    (bus.wa),
      .wd_i    (bus.wd),
      .pc_inc_i(bus.pc_inc),
      .sp_inc_i(bus.sp_inc),
      .sp_dec_i(bus.sp_dec),
      .st_wr_i (bus.st_wr),
      .st_in_i (bus.st_in),
      .nxt_o   (regs_d[i])
    );
  end

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
`ifdef REGFILE_BYPASS_EN
      rd_d[k] = regs_d[bus.ra[slice_lo(k, AW) +: AW]];
`else
      rd_d[k] = regs_q[bus.ra[slice_lo(k, AW) +: AW]];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      rd_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      for (int k = 0; k < NRD; k++)
        if (bus.rd_en[k]) rd_q[slice_lo(k, DW) +: DW] <= rd_d[k];
    end
  end

  assign bus.rd     = rd_q;
  assign bus.pc_out = regs_q[PC_IDX];
  assign bus.sp_out = regs_q[SP_IDX];
  assign bus.lr_out = regs_q[LR_IDX];
  assign bus.st_out = regs_q[ST_IDX];
endmodule

// File: tb/tb_regfile_mp_pc.sv
// Randomized + directed bench for regfile_mp_pc against an array-based reference model.
module tb_regfile_mp_pc;
  localparam int DW = 32, AW = 5, NRD = 2, NWR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_pc_if #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR)) bus ();
  regfile_mp_pc #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mreg [32];
  logic [DW-1:0] mrd  [NRD];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.rd_en = '0; bus.ra = '0; bus.wr_en = '0; bus.wa = '0; bus.wd = '0;
    bus.st_in = '0; bus.st_wr = 1'b0; bus.pc_inc = 1'b0; bus.sp_inc = 1'b0; bus.sp_dec = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    bus.wr_en[p] = 1'b1;
    bus.wa[p*AW +: AW] = AW'(a);
    bus.wd[p*DW +: DW] = d;
  endtask

  task automatic rdp(input int p, input int a);
    bus.rd_en[p] = 1'b1;
    bus.ra[p*AW +: AW] = AW'(a);
  endtask

  // Clock one edge, advance the model from the architectural rules, compare every output.
  task automatic cycle();
    logic [DW-1:0] nx [32];
    bit pc_w, sp_w;
    int a;
    @(posedge clk);
    #1;
    if (rst) begin
      foreach (mreg[i]) mreg[i] = '0;
      foreach (mrd[k]) mrd[k] = '0;
    end else begin
      nx = mreg;
      pc_w = 0; sp_w = 0;
      for (int p = 0; p < NWR; p++) begin
        if (bus.wr_en[p]) begin
          a = int'(bus.wa[p*AW +: AW]);
          if (a == 31) pc_w = 1;
          if (a == 30) sp_w = 1;
          if (a != 0) nx[a] = bus.wd[p*DW +: DW];
        end
      end
      if (!pc_w && bus.pc_inc) nx[31] = mreg[31] + 1;
      if (!sp_w && bus.sp_inc && !bus.sp_dec) nx[30] = mreg[30] + 1;
      if (!sp_w && bus.sp_dec && !bus.sp_inc) nx[30] = mreg[30] - 1;
      if (bus.st_wr) nx[28] = bus.st_in;
      for (int k = 0; k < NRD; k++) begin
        if (bus.rd_en[k]) begin
          a = int'(bus.ra[k*AW +: AW]);
`ifdef REGFILE_BYPASS_EN
          mrd[k] = nx[a];
`else
          mrd[k] = mreg[a];
`endif
        end
      end
      mreg = nx;
    end
    chk("rd0", bus.rd[0 +: DW], mrd[0]);
    chk("rd1", bus.rd[DW +: DW], mrd[1]);
    chk("pc", bus.pc_out, mreg[31]);
    chk("sp", bus.sp_out, mreg[30]);
    chk("lr", bus.lr_out, mreg[29]);
    chk("st", bus.st_out, mreg[28]);
  endtask

  function automatic int raddr();
    return ($urandom % 2) ? int'($urandom_range(28, 31)) : int'($urandom_range(0, 7));
  endfunction

  task automatic rand_cycle(input bit allow_rst);
    idle();
    for (int p = 0; p < NWR; p++) if ($urandom % 2) wr(p, raddr(), $urandom);
    for (int k = 0; k < NRD; k++) if ($urandom % 2) rdp(k, raddr());
    bus.pc_inc = 1'($urandom);
    bus.sp_inc = 1'($urandom);
    bus.sp_dec = 1'($urandom);
    bus.st_wr  = ($urandom % 4) == 0;
    bus.st_in  = $urandom;
    rst = allow_rst && ($urandom % 64) == 0;
    cycle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cycle();

    // Reset after filling registers.
    for (int i = 0; i < 32; i++) begin
      idle(); wr(0, i, $urandom | 32'h1); rdp(0, i); rdp(1, 31 - i);
      cycle();
    end
    idle(); rst = 1'b1; bus.wr_en = '1; bus.pc_inc = 1'b1;
    cycle();
    chk("rst_rd0", bus.rd[0 +: DW], 32'h0);
    chk("rst_rd1", bus.rd[DW +: DW], 32'h0);
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_sp", bus.sp_out, 32'h0);
    chk("rst_lr", bus.lr_out, 32'h0);
    chk("rst_st", bus.st_out, 32'h0);

    // Port conflict: highest port wins.
    idle(); wr(0, 5, 32'hAAAA); wr(1, 5, 32'h5555); cycle();
    idle(); rdp(0, 5); cycle();
    chk("conflict", bus.rd[0 +: DW], 32'h5555);

    // PC wrap, then branch beats increment.
    idle(); wr(1, 31, 32'hFFFF_FFFF); cycle();
    idle(); bus.pc_inc = 1'b1; cycle();
    chk("pc_wrap", bus.pc_out, 32'h0);
    idle(); bus.pc_inc = 1'b1; wr(0, 31, 32'h100); cycle();
    chk("pc_branch", bus.pc_out, 32'h100);

    // Status strobe beats port write.
    idle(); bus.st_wr = 1'b1; bus.st_in = 32'h3; wr(1, 28, 32'h9); cycle();
    chk("st_prio", bus.st_out, 32'h3);

    // Zero register.
    idle(); wr(0, 0, 32'h1234); cycle();
    idle(); rdp(1, 0); cycle();
    chk("r0_zero", bus.rd[DW +: DW], 32'h0);

    // SP inc+dec cancel; dec wraps from 0.
    idle(); wr(0, 30, 32'h10); cycle();
    idle(); bus.sp_inc = 1'b1; bus.sp_dec = 1'b1; cycle();
    chk("sp_both", bus.sp_out, 32'h10);
    idle(); wr(1, 30, 32'h0); cycle();
    idle(); bus.sp_dec = 1'b1; cycle();
    chk("sp_wrap", bus.sp_out, 32'hFFFF_FFFF);

    // Same-cycle read/write of r7.
    idle(); wr(0, 7, 32'h1); cycle();
    idle(); wr(1, 7, 32'h2); rdp(0, 7); cycle();
`ifdef REGFILE_BYPASS_EN
    chk("bypass", bus.rd[0 +: DW], 32'h2);
`else
    chk("bypass", bus.rd[0 +: DW], 32'h1);
`endif

    for (int n = 0; n < 1500; n++) rand_cycle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp_pc.md
# regfile_mp_pc

Parametrised multi-port CPU register file with dedicated program-counter, stack-pointer, link and status registers; next generation of the 2-read/2-write CPU32 register file. Sits between decode and execute: registered read ports feed operands, write ports take execute/load results, and side-band controls advance the PC and update status every cycle. Adds configurable port count, a hardwired zero register, deterministic write priority, PC/SP arithmetic and optional write-to-read bypass.

## Interface

- DW, 32, data/register width
- AW, 5, register address width; depth = 2**AW
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- ZERO_R0, 1, 1 = register 0 reads 0 and ignores writes
- PC_IDX / SP_IDX / LR_IDX / ST_IDX, 31 / 30 / 29 / 28, special register indices (distinct, nonzero)
- SP_STEP, 1, SP increment/decrement amount

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_en  in  NRD  per-port read enable
- ra  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- rd  out  NRD*DW  registered read data, port k at [k*DW +: DW]
- wr_en  in  NWR  per-port write enable
- wa  in  NWR*AW  write addresses
- wd  in  NWR*DW  write data
- st_in  in  DW  status write data
- st_wr  in  1  status write strobe
- pc_inc  in  1  PC += 1
- sp_inc / sp_dec  in  1 / 1  SP += / -= SP_STEP
- pc_out / sp_out / lr_out / st_out  out  DW each  live (combinational) contents of special registers

## Operation

- Reset (rst=1 at clk edge): all registers 0, all rd ports 0; all other inputs ignored that cycle.
- Read port k: rd_en[k]=1 -> rd[k] loads regs[ra[k]] at the edge; rd_en[k]=0 -> rd[k] holds.
- ZERO_R0=1: reads of address 0 return 0; writes to 0 discarded.
- Write ports: all enabled ports commit at the same edge. Same address on several ports: highest port index wins.
- PC: any port write to PC_IDX overrides pc_inc (branch beats increment). Otherwise pc_inc adds 1 mod 2**DW (0xFFFFFFFF -> 0).
- SP: port write to SP_IDX overrides sp_inc/sp_dec. sp_inc and sp_dec together: no change. Arithmetic mod 2**DW.
- ST: st_wr overrides any port write to ST_IDX (flags from ALU win).
- LR: ordinary register; no side-band.
- Special-register outputs reflect the register array (post-edge values), never bypassed.

## Timing

- Read latency: 1 cycle (address at edge n, data valid after edge n).
- Write latency: 1 cycle; written value visible on pc_out/sp_out/lr_out/st_out after the same edge.
- Read and write of the same address in one cycle: see Configuration.
- No handshake; all ports accept every cycle. rst mid-operation discards all pending writes and increments in that cycle.

## Configuration

- REGFILE_BYPASS_EN defined: write-first; a read of an address being written in the same cycle returns the final resolved value (after port priority, pc_inc, sp_inc/dec, st_wr), i.e. exactly what the register holds after the edge.
- Undefined: read-first; read returns the pre-edge value. Address 0 with ZERO_R0=1 returns 0 either way.

## Structure

- Package regfile_pkg: default special-index constants, SP_STEP default, helper function for per-port slice extraction.
- Sub-module regfile_wr_arb: per-register next-value resolver (port priority, side-band override, zero-reg masking), instantiated once per register via generate.

## Test plan

- Reset: write all regs, assert rst -> every rd, pc_out, sp_out, lr_out, st_out = 0 one cycle later.
- Port conflict: wr_en=2'b11, wa0=wa1=5, wd0=0xAAAA, wd1=0x5555 -> reg5 = 0x5555.
- PC wrap/branch: PC=0xFFFFFFFF, pc_inc=1 -> pc_out=0; next cycle pc_inc=1 with port write PC=0x100 -> pc_out=0x100.
- Status priority: st_wr=1 st_in=0x3, port write ST=0x9 same cycle -> st_out=0x3.
- Zero reg / SP: write 0x1234 to r0 -> read r0 = 0; sp_inc and sp_dec together with SP=0x10 -> SP stays 0x10; sp_dec alone at SP=0 -> 0xFFFFFFFF.
- Bypass: r7=1, write r7=2 and read r7 same cycle -> rd=2 with REGFILE_BYPASS_EN, rd=1 without.
